// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Brief    : VGA timing generator and pixel output stage. Produces the X/Y
//            coordinate stream for the draw block, delays sync/blank to meet
//            the returned colour, and registers all DAC pins.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int   H_VISIBLE    = 640,
    parameter int   H_FRONT      = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BACK       = 48,
    parameter int   V_VISIBLE    = 480,
    parameter int   V_FRONT      = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BACK       = 33,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   DRAW_LATENCY = 1
) (
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic       iRed,
    input  logic       iGreen,
    input  logic       iBlue,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic       oRequest,
    output logic       oFrame_Start,
    output logic       oVGA_R,
    output logic       oVGA_G,
    output logic       oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N
);

    localparam int         C_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int         C_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] C_H_LAST   = 10'(C_H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST   = 10'(C_V_TOTAL - 1);
    localparam logic [9:0] C_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] C_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] C_HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] C_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] C_VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] C_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_vis;
    logic       w_hs_act;
    logic       w_vs_act;
    logic [2:0] w_tap;

    // Delay line element: {vis, hs_act, vs_act}
    logic [2:0] r_dly [DRAW_LATENCY];

    logic r_red;
    logic r_green;
    logic r_blue;
    logic r_blank_n;
    logic r_hs;
    logic r_vs;

    // Raster counters: pixel counter wraps each line, line counter advances at line end
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == C_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Coordinate-stage decode straight from the counters
    assign w_vis        = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);
    assign w_hs_act     = (r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END);
    assign w_vs_act     = (r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END);
    assign oRequest     = w_vis;
    assign oVGA_X       = w_vis ? r_h_cnt : 10'd0;
    assign oVGA_Y       = w_vis ? r_v_cnt : 10'd0;
    assign oFrame_Start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    // Delay vis/sync by the draw block latency so they meet the returned colour
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            for (int i = 0; i < DRAW_LATENCY; i++) begin
                r_dly[i] <= 3'b000;
            end
        end else begin
            r_dly[0] <= {w_vis, w_hs_act, w_vs_act};
            for (int i = 1; i < DRAW_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_tap = r_dly[DRAW_LATENCY-1];

    // Pin register: blank colour outside the visible area, apply sync polarity
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            r_red     <= 1'b0;
            r_green   <= 1'b0;
            r_blue    <= 1'b0;
            r_blank_n <= 1'b0;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
        end else begin
            r_red     <= iRed   & w_tap[2];
            r_green   <= iGreen & w_tap[2];
            r_blue    <= iBlue  & w_tap[2];
            r_blank_n <= w_tap[2];
            r_hs      <= w_tap[1] ? SYNC_POL : ~SYNC_POL;
            r_vs      <= w_tap[0] ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign oVGA_R       = r_red;
    assign oVGA_G       = r_green;
    assign oVGA_B       = r_blue;
    assign oVGA_BLANK_N = r_blank_n;
    assign oVGA_HS      = r_hs;
    assign oVGA_VS      = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Brief    : Self-checking bench for vga_timing_ctrl. Uses a shrunken raster so
//            several whole frames fit in a short run; expected values come from
//            a cycle-index arithmetic model of the raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    localparam int HV = 20, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int LAT   = 1;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset;
    logic       iRed, iGreen, iBlue;
    logic [9:0] oVGA_X, oVGA_Y;
    logic       oRequest, oFrame_Start;
    logic       oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK_N;

    int n_cmp  = 0;
    int n_fail = 0;
    int n      = 0;     // cycles since the last reset release
    int abs_c  = 0;     // free-running cycle count
    int last_fs = -1;
    bit in_r[$];        // colour returned by the draw model, per coordinate cycle
    bit in_g[$];
    bit in_b[$];

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .DRAW_LATENCY(LAT)
    ) dut (
        .iVGA_CLK(clk), .reset(reset),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oVGA_X(oVGA_X), .oVGA_Y(oVGA_Y),
        .oRequest(oRequest), .oFrame_Start(oFrame_Start),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // Compare every output against the raster model for the current cycle
    task automatic check_cycle();
        int h, v, c, ch, cv;
        bit vis, cvis, hs_on, vs_on;
        logic [5:0] e;
        h   = n % HT;
        v   = (n / HT) % VT;
        vis = (h < HV) && (v < VV);
        chk("x", 32'(oVGA_X), vis ? h : 0);
        chk("y", 32'(oVGA_Y), vis ? v : 0);
        chk("request", 32'(oRequest), 32'(vis));
        chk("frame_start", 32'(oFrame_Start), 32'((h == 0) && (v == 0)));
        if (n < LAT + 1) begin
            e = 6'b000011;
        end else begin
            c     = n - LAT - 1;
            ch    = c % HT;
            cv    = (c / HT) % VT;
            cvis  = (ch < HV) && (cv < VV);
            hs_on = (ch >= HV + HF) && (ch < HV + HF + HS);
            vs_on = (cv >= VV + VF) && (cv < VV + VF + VS);
            e = {cvis & in_r[c], cvis & in_g[c], cvis & in_b[c], cvis, !hs_on, !vs_on};
        end
        chk("pins_rgbnhv", 32'({oVGA_R, oVGA_G, oVGA_B, oVGA_BLANK_N, oVGA_HS, oVGA_VS}), 32'(e));
    endtask

    // mode 0: draw model (R=X[0], G=Y[0], B=random); 1: all ones; 2: random mix
    task automatic run_cycle(input int mode);
        bit f;
        check_cycle();
        if (oFrame_Start) begin
            if (last_fs >= 0) chk("frame_period", 32'(abs_c - last_fs), 32'(FRAME));
            last_fs = abs_c;
        end
        f = (mode == 1) || (mode == 2 && ($urandom % 3 == 0));
        if (f) begin
            in_r.push_back(1'b1); in_g.push_back(1'b1); in_b.push_back(1'b1);
        end else begin
            in_r.push_back(oVGA_X[0]); in_g.push_back(oVGA_Y[0]);
            in_b.push_back(1'($urandom));
        end
        if (n >= LAT) begin
            iRed = in_r[n-LAT]; iGreen = in_g[n-LAT]; iBlue = in_b[n-LAT];
        end else begin
            iRed = 1'b1; iGreen = 1'b1; iBlue = 1'b1;
        end
        @(posedge clk); #1;
        n++;
        abs_c++;
    endtask

    task automatic restart_model();
        n = 0;
        last_fs = -1;
        in_r.delete(); in_g.delete(); in_b.delete();
    endtask

    initial begin
        int th, tv;
        reset = 1'b1; iRed = 1'b1; iGreen = 1'b1; iBlue = 1'b1;

        // Reset held: pins quiet, counters at origin
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            abs_c++;
            chk("rst_x", 32'(oVGA_X), 32'd0);
            chk("rst_y", 32'(oVGA_Y), 32'd0);
            chk("rst_request", 32'(oRequest), 32'd1);
            chk("rst_frame_start", 32'(oFrame_Start), 32'd1);
            chk("rst_pins_rgbnhv", 32'({oVGA_R, oVGA_G, oVGA_B, oVGA_BLANK_N, oVGA_HS, oVGA_VS}),
                32'(6'b000011));
        end

        reset = 1'b0;
        restart_model();

        // Normal draw model for one frame plus a line; then blanking with forced ones
        for (int k = 0; k < FRAME + HT; k++) run_cycle(0);
        for (int k = 0; k < FRAME; k++) run_cycle(1);

        // Reset in the middle of a frame at a random visible coordinate
        th = $urandom_range(1, HV - 2);
        tv = $urandom_range(1, VV - 2);
        for (int k = 0; k < FRAME; k++) begin
            if ((n % HT == th) && ((n / HT) % VT == tv)) break;
            run_cycle(2);
        end
        chk("mid_reset_x", 32'(oVGA_X), 32'(th));
        chk("mid_reset_y", 32'(oVGA_Y), 32'(tv));
        check_cycle();
        reset = 1'b1; iRed = 1'b1; iGreen = 1'b1; iBlue = 1'b1;
        @(posedge clk); #1;
        abs_c++;
        reset = 1'b0;
        restart_model();

        // Recovery: full frame with random colour mix, including the next frame start
        for (int k = 0; k < FRAME + 2 * HT; k++) run_cycle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- VGA timing generator and output stage: the other end of the pixel interface consumed by the sprite/colour draw block.
- Generates the pixel coordinate stream (X/Y) that the draw block reads.
- Accepts the 1-bit-per-channel RGB the draw block returns, aligns it with delayed HSYNC/VSYNC/BLANK_N, and drives the VGA DAC pins.
- Default timing is 640x480@60 Hz on a 25 MHz pixel clock.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- DRAW_LATENCY, 1, cycles from X/Y presented to colour valid on iRed/iGreen/iBlue (1..4)

Ports:
- iVGA_CLK  in  1  pixel clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- iRed  in  1  red from draw block
- iGreen  in  1  green from draw block
- iBlue  in  1  blue from draw block
- oVGA_X  out  10  current pixel column to draw block
- oVGA_Y  out  10  current pixel row to draw block
- oRequest  out  1  high while (oVGA_X,oVGA_Y) is in the visible area
- oFrame_Start  out  1  one-cycle pulse at counter origin (0,0)
- oVGA_R  out  1  red pin, blanked
- oVGA_G  out  1  green pin, blanked
- oVGA_B  out  1  blue pin, blanked
- oVGA_HS  out  1  horizontal sync pin
- oVGA_VS  out  1  vertical sync pin
- oVGA_BLANK_N  out  1  DAC blank, low outside visible area

Behaviour:
- One clock (iVGA_CLK). reset is synchronous and active-high; sampled on the rising edge only.
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Counters are 10-bit registers h_cnt and v_cnt.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only in the cycle h_cnt == H_TOTAL-1, and wraps to 0 after V_TOTAL-1 (line end and frame end coincide at (799,524)).
- Coordinate stage (cycle t), combinational from the counters:
  - vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - oRequest = vis.
  - oVGA_X = vis ? h_cnt : 0; oVGA_Y = vis ? v_cnt : 0.
  - oFrame_Start = (h_cnt == 0 && v_cnt == 0).
- Sync decode at cycle t:
  - hs_act = h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 656..751.
  - vs_act = v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. 490..491.
- Alignment pipeline:
  - vis, hs_act and vs_act pass through a DRAW_LATENCY-deep shift register, then one output register.
  - At the output register: oVGA_HS = hs_act ? SYNC_POL : ~SYNC_POL (same for VS); oVGA_BLANK_N = vis_d; oVGA_R/G/B = iRed/iGreen/iBlue & vis_d.
  - Net result: pin outputs for coordinate t appear at cycle t+DRAW_LATENCY+1.
- Reset values (all registers):
  - h_cnt = 0, v_cnt = 0.
  - Delay line cleared to vis = 0, sync inactive.
  - oVGA_R/G/B = 0, oVGA_BLANK_N = 0, oVGA_HS = oVGA_VS = ~SYNC_POL.
- Reset-derived combinational outputs: with counters at 0, oVGA_X = oVGA_Y = 0, oRequest = 1 and oFrame_Start = 1 while reset is held.
- First cycle after release: counters are (0,0). The first frame is complete; no partial frame.
- Reset mid-frame: next edge returns counters to (0,0) and flushes the delay line. No stale sync or colour reaches the pins after release.
- Blanking: pins show black whenever vis_d = 0, regardless of iRed/iGreen/iBlue.
- Draw-block inputs are ignored outside the visible area.
- No back-pressure: the coordinate stream never stalls.

Test Plan:
1. Reset: hold reset 5 cycles with iRed = iGreen = iBlue = 1 -> R/G/B = 0, BLANK_N = 0, HS = VS = 1, X = Y = 0, oFrame_Start = 1.
2. Line timing: release reset at cycle 0 (DRAW_LATENCY = 1) -> HS low for cycles 658..753 exactly (96 cycles). Period is 800 cycles. oVGA_X counts 0..639, then reads 0 for cycles 640..799.
3. Frame timing: oFrame_Start pulses exactly every 420000 cycles. VS low for 1600 cycles starting at cycle 490·800+2. oVGA_Y reaches 479 and never exceeds it.
4. Alignment: draw model with 1-cycle register returns iRed = X[0], iGreen = Y[0], iBlue = 1 -> at every pin cycle with BLANK_N = 1, R/G match the X/Y issued 2 cycles earlier. First visible pin pixel is at cycle 2.
5. Blanking: iRed/iGreen/iBlue forced to 1 -> R/G/B = 0 whenever BLANK_N = 0, including the porch and sync regions.
6. Mid-frame reset: assert reset at (h,v) = (300,250) for 1 cycle -> counters at (0,0) on the next cycle. Pins show HS/VS inactive and blank for 2 cycles, then normal output.
